// File: rtl/grf_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the hard-wired zero register, slice helper and address/data types.
package grf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register 0 reads zero, is never written and is never pending.
  localparam int REG_ZERO = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // Low bit of port idx inside a flattened vector of w-bit fields.
  // Use as vec[slice_lo(idx, w) +: w].
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/grf_mp_if.sv
// Bus between decode/writeback and the register file. The pipeline side
// uses the master modport, the register file the slave modport.
interface grf_mp_if
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic [NUM_WR-1:0]        we;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic [NUM_WR*32-1:0]     pc_w;
  logic                     any_busy;

  modport master (
    output ra, wa, wd, we, iss_valid, iss_addr, pc_w,
    input  rd, rd_busy, any_busy
  );

  modport slave (
    input  ra, wa, wd, we, iss_valid, iss_addr, pc_w,
    output rd, rd_busy, any_busy
  );

endinterface

// File: rtl/grf_read_port.sv
// One read port: compares its address against every writer, forwards the
// highest-index matching write data, and hides the busy bit when the
// producer is writing back in this very cycle.
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = 2
) (
  input  logic [ADDR_W-1:0]        ra,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [NUM_WR-1:0]        we,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     st_pend,
  output logic [DATA_W-1:0]        rd,
  output logic                     busy
);

  logic              hit;
  logic [DATA_W-1:0] byp;

  // Priority bypass: later ports overwrite earlier matches, so the highest index wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hit = 1'b0;
    byp = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j] && (wa[slice_lo(j, ADDR_W) +: ADDR_W] == ra) &&
          (ra != ADDR_W'(REG_ZERO))) begin
        hit = 1'b1;
        byp = wd[slice_lo(j, DATA_W) +: DATA_W];
      end
    end
    rd   = hit ? byp : st_data;
    busy = st_pend & ~hit;
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with write-pending scoreboard.
// Optional build macro GRF_TRACE_EN: prints one line per enabled write port
// at each clock edge; when undefined pc_w is ignored.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input logic      clk,
  input logic      reset,
  grf_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [NUM_WR-1:0] we_eff;

  // While reset is held nothing may be forwarded, so reads see the cleared storage.
  assign we_eff = reset ? '0 : bus.we;

  // Register storage: ascending port loop lets the higher-index writer land last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the array is reset because architectural state must read zero after reset; it is flops, not a RAM macro.
      for (int k = 0; k < DEPTH; k++) gpr[k] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.we[j] && (bus.wa[slice_lo(j, ADDR_W) +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
          // NOTE: non-blocking assignment; with two writers to one address the last one in loop order takes effect.
          gpr[bus.wa[slice_lo(j, ADDR_W) +: ADDR_W]] <= bus.wd[slice_lo(j, DATA_W) +: DATA_W];
        end
      end
    end
  end

  // Scoreboard: writebacks clear, then an issue sets, so issue wins on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.we[j] && (bus.wa[slice_lo(j, ADDR_W) +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
          pending[bus.wa[slice_lo(j, ADDR_W) +: ADDR_W]] <= 1'b0;
        end
      end
      if (bus.iss_valid && (bus.iss_addr != ADDR_W'(REG_ZERO))) begin
        pending[bus.iss_addr] <= 1'b1;
      end
    end
  end

  assign bus.any_busy = |pending;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    logic [DATA_W-1:0] rd_i;
    logic              busy_i;

    assign ra_i = bus.ra[i*ADDR_W +: ADDR_W];

    grf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_rp (
      .ra      (ra_i),
      .wa      (bus.wa),
      .wd      (bus.wd),
      .we      (we_eff),
      .st_data (gpr[ra_i]),
      .st_pend (pending[ra_i]),
      .rd      (rd_i),
      .busy    (busy_i)
    );

    assign bus.rd[i*DATA_W +: DATA_W] = rd_i;
    assign bus.rd_busy[i]             = busy_i;
  end

`ifdef GRF_TRACE_EN
  // Writeback trace, one line per enabled port in ascending port order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.we[j]) begin
          $display("%d@%h: $%d <= %h", $time, bus.pc_w[j*32 +: 32],
                   bus.wa[slice_lo(j, ADDR_W) +: ADDR_W],
                   (bus.wa[slice_lo(j, ADDR_W) +: ADDR_W] == ADDR_W'(REG_ZERO)) ?
                     {DATA_W{1'b0}} : bus.wd[slice_lo(j, DATA_W) +: DATA_W]);
        end
      end
    end
  end
`endif

endmodule
